// File: rtl/sar_search_ctrl_if.sv
// Comparator-side bundle for the SAR controller: start request, lt/gt/eq answers in; trial value and search results out.
interface sar_search_ctrl_if #(
  parameter int WIDTH = 4
);
  localparam int SW = $clog2(WIDTH + 1);

  logic             start;
  logic             A_lt_B;
  logic             A_gt_B;
  logic             A_eq_B;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;
  logic [SW-1:0]    steps;

  modport master (
    input  start, A_lt_B, A_gt_B, A_eq_B,
    output guess, busy, done, result, err, steps
  );

  modport slave (
    output start, A_lt_B, A_gt_B, A_eq_B,
    input  guess, busy, done, result, err, steps
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search, MSB first, over a lt/gt/eq comparator; SAR_EARLY_EXIT_EN ends a search on a legal eq.
// One trial per cycle, done pulses WIDTH+1 cycles after start; start is only accepted while idle.
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  sar_search_ctrl_if.master bus
);
  localparam int KW = $clog2(WIDTH);
  localparam int SW = $clog2(WIDTH + 1);

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIAL,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] guess_q;
  logic [WIDTH-1:0] guess_nx;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_nx;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    k_nx;
  logic [SW-1:0]    steps_q;
  logic [SW-1:0]    steps_nx;
  logic             err_q;
  logic             err_nx;

  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] decided;
  logic             code_ok;

  assign bit_k = {{(WIDTH-1){1'b0}}, 1'b1} << k_q;

  // Target below the trial value means bit k of the target is 0.
  assign decided = bus.A_lt_B ? (guess_q & ~bit_k) : guess_q;

  assign code_ok = (bus.A_lt_B ^ bus.A_gt_B ^ bus.A_eq_B) &
                   ~(bus.A_lt_B & bus.A_gt_B & bus.A_eq_B);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guess_q  <= '0;
      result_q <= '0;
      k_q      <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      guess_q  <= guess_nx;
      result_q <= result_nx;
      k_q      <= k_nx;
      steps_q  <= steps_nx;
      err_q    <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    guess_nx  = guess_q;
    result_nx = result_q;
    k_nx      = k_q;
    steps_nx  = steps_q;
    err_nx    = err_q;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = S_TRIAL;
          guess_nx = {1'b1, {(WIDTH-1){1'b0}}};
          k_nx     = KW'(WIDTH - 1);
          steps_nx = '0;
          err_nx   = 1'b0;
        end
      end

      S_TRIAL: begin
        steps_nx = steps_q + 1'b1;
        if (!code_ok) begin
          err_nx    = 1'b1;
          result_nx = '0;
          state_nx  = S_DONE;
        end else if (EARLY_EXIT && bus.A_eq_B) begin
          result_nx = guess_q;
          state_nx  = S_DONE;
        end else if (k_q != '0) begin
          guess_nx = decided | (bit_k >> 1);
          k_nx     = k_q - 1'b1;
        end else begin
          guess_nx  = decided;
          result_nx = decided;
          state_nx  = S_DONE;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.guess  = guess_q;
  assign bus.result = result_q;
  assign bus.steps  = steps_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state == S_TRIAL);
  assign bus.done   = (state == S_DONE);

  // During a trial only the bits above k are decided and bit k is the probe.
  a_low_bits_clear: assert property (@(posedge clk) disable iff (reset)
    (state == S_TRIAL) |-> ((guess_q & (bit_k - 1'b1)) == '0));

  a_probe_bit_set: assert property (@(posedge clk) disable iff (reset)
    (state == S_TRIAL) |-> ((guess_q & bit_k) != '0));

  a_steps_bounded: assert property (@(posedge clk) disable iff (reset)
    steps_q <= SW'(WIDTH));

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Randomized scoreboard bench: a comparator model answers the DUT's trials, a monitor checks every trial and result.
module tb_sar_search_ctrl;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           steps;
    int           e0;
  } exp_t;

  typedef struct {
    logic [W-1:0] g;
    int           idx;
  } trial_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sar_search_ctrl_if #(.WIDTH(W)) bus ();

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] target = '0;
  logic         fault_on = 1'b0;
  logic [2:0]   fault_code = 3'b000;

  always_comb begin
    if (fault_on) begin
      {bus.A_lt_B, bus.A_gt_B, bus.A_eq_B} = fault_code;
    end else begin
      bus.A_lt_B = (target < bus.guess);
      bus.A_gt_B = (target > bus.guess);
      bus.A_eq_B = (target == bus.guess);
    end
  end

  exp_t   exp_q[$];
  trial_t trial_q[$];
  exp_t   cur_e;
  trial_t cur_t;

  int vectors = 0;
  int miscompares = 0;
  int ec = 0;
  logic [W-1:0] last_res = '0;
  logic         last_err = 1'b0;
  int           last_steps = 0;

  always @(posedge clk) ec <= ec + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: trial j probes bit k=W-1-j with the target's bits above k already known.
  task automatic push_expect(input logic [W-1:0] t, input int fault_trial, input int e0, output int n);
    exp_t   e;
    trial_t tr;
    int     tv;
    int     k;
    int     g;
    tv      = int'(t);
    e.err   = 1'b0;
    e.res   = t;
    e.steps = W;
    e.e0    = e0;
    for (int j = 0; j < W; j++) begin
      k = W - 1 - j;
      g = ((tv >> (k + 1)) << (k + 1)) | (1 << k);
      tr.g   = g[W-1:0];
      tr.idx = j + 1;
      trial_q.push_back(tr);
      if (j + 1 == fault_trial) begin
        e.err   = 1'b1;
        e.res   = '0;
        e.steps = j + 1;
        break;
      end
`ifdef SAR_EARLY_EXIT_EN
      if (g == tv) begin
        e.steps = j + 1;
        break;
      end
`endif
    end
    exp_q.push_back(e);
    n = e.steps;
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic run(input logic [W-1:0] t, input int fault_trial, input logic [2:0] fcode,
                     input bit poke, input bit hold);
    int n;
    int e0;
    target     = t;
    fault_code = fcode;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    e0 = ec;
    push_expect(t, fault_trial, e0, n);
    for (int c = 1; c <= n + 1; c++) begin
      bus.start = hold || (poke && (c == 2 || c == n + 1));
      fault_on  = (c == fault_trial);
      @(posedge clk);
      #1;
    end
    fault_on  = 1'b0;
    bus.start = hold;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_guess"}, int'(bus.guess), 0);
    check({tag, "_result"}, int'(bus.result), 0);
    check({tag, "_steps"}, int'(bus.steps), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_err"}, int'(bus.err), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.busy) begin
        check("busy_with_done", int'(bus.done), 0);
        if (trial_q.size() == 0) begin
          check("unexpected_trial", 1, 0);
        end else begin
          cur_t = trial_q.pop_front();
          check("guess", int'(bus.guess), int'(cur_t.g));
          check("steps_in_trial", int'(bus.steps), cur_t.idx - 1);
          check("err_in_trial", int'(bus.err), 0);
        end
      end else if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          cur_e = exp_q.pop_front();
          check("result", int'(bus.result), int'(cur_e.res));
          check("err", int'(bus.err), int'(cur_e.err));
          check("steps", int'(bus.steps), cur_e.steps);
          check("done_latency", ec - cur_e.e0, cur_e.steps);
          check("trials_left", trial_q.size(), 0);
          trial_q.delete();
          last_res   = cur_e.res;
          last_err   = cur_e.err;
          last_steps = cur_e.steps;
        end
      end else begin
        check("idle_result", int'(bus.result), int'(last_res));
        check("idle_err", int'(bus.err), int'(last_err));
        check("idle_steps", int'(bus.steps), last_steps);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before t=500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] codes [5];
    int         n6;
    int         e6;
    int         ft;
    bit         hold;
    codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    run(4'd11, 0, 3'b000, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    run(4'd0, 0, 3'b000, 1'b0, 1'b1);
    run(4'd15, 0, 3'b000, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    run(4'd11, 0, 3'b000, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    run(4'd11, 2, 3'b000, 1'b0, 1'b0);
    run(4'd11, 0, 3'b000, 1'b0, 1'b0);

    run(4'd8, 0, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of the third trial.
    target    = 4'd11;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e6 = ec;
    push_expect(4'd11, 0, e6, n6);
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    trial_q.delete();
    last_res   = '0;
    last_err   = 1'b0;
    last_steps = 0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run(4'd5, 0, 3'b000, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ft   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W)) : 0;
      hold = (i != 59) && ($urandom_range(0, 3) == 0);
      run(W'($urandom_range(0, (1 << W) - 1)), ft, codes[$urandom_range(0, 4)],
          1'($urandom_range(0, 1)), hold);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end

    repeat (4) begin @(posedge clk); #1; end
    check("pending_results", exp_q.size(), 0);
    check("pending_trials", trial_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
